// File: rtl/pad_ctrl_pkg.sv
// Shared constants and types for the APB pad configuration block.
package pad_ctrl_pkg;
    localparam int NUM_PADS      = 48;
    localparam int PAD_CFG_W     = 6;
    localparam int PADS_PER_WORD = 4;

    localparam logic [5:0] PADCFG_BASE = 6'h00;
    localparam logic [5:0] BOOTSEL_OFS = 6'h30;
    localparam logic [5:0] LOCK_OFS    = 6'h34;

    typedef logic [PAD_CFG_W-1:0] pad_cfg_t;

    typedef enum logic {
        BS_FILTER,
        BS_DONE
    } bootsel_state_e;
endpackage

// File: rtl/pad_bootsel_filter.sv
// Synchronizes the raw boot-select pads and latches them once they have held
// steady for BOOT_STABLE_CYCLES cycles; the result is frozen until reset.
module pad_bootsel_filter
    import pad_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_STABLE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] bootsel_i,
    output logic [1:0] bootsel_o,
    output logic       valid_o
);
    localparam int CNT_W = $clog2(BOOT_STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOOT_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    bootsel_state_e   state_q, state_d;
    logic [1:0]       s1_q, s2_q;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       boot_q, boot_d;
    logic             valid_q, valid_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= '0;
            s2_q    <= '0;
            state_q <= BS_FILTER;
            cand_q  <= '0;
            cnt_q   <= '0;
            boot_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            s1_q    <= bootsel_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            boot_q  <= boot_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        boot_d  = boot_q;
        valid_d = valid_q;
        unique case (state_q)
            BS_FILTER: begin
                if (s2_q != cand_q) begin
                    cand_d = s2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    boot_d  = cand_q;
                    valid_d = 1'b1;
                    state_d = BS_DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BS_DONE: ;
            default: state_d = BS_FILTER;
        endcase
    end

    assign bootsel_o = boot_q;
    assign valid_o   = valid_q;
endmodule

// File: rtl/apb_pad_ctrl.sv
// APB3 zero-wait-state register slave driving the pad frame configuration
// vector, with a sticky lock and a filtered boot-select status register.
module apb_pad_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_STABLE_CYCLES = 16,
    parameter int unsigned APB_ADDR_W         = 12
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 psel_i,
    input  logic                                 penable_i,
    input  logic                                 pwrite_i,
    input  logic [APB_ADDR_W-1:0]                paddr_i,
    input  logic [31:0]                          pwdata_i,
    output logic [31:0]                          prdata_o,
    output logic                                 pready_o,
    output logic                                 pslverr_o,
    input  logic [1:0]                           bootsel_i,
    output logic [NUM_PADS-1:0][PAD_CFG_W-1:0]   pad_cfg_o,
    output logic [1:0]                           bootsel_o,
    output logic                                 bootsel_valid_o
);
    // Four pads per 32-bit word, so a PADCFG byte offset equals its first pad index.
    localparam logic [5:0] PADCFG_END = PADCFG_BASE + 6'(NUM_PADS);

    pad_cfg_t [NUM_PADS-1:0] pad_q, pad_d;
    logic                    lock_q, lock_d;
    logic [5:0]              word_ofs, pad_base;
    logic                    access, is_pad, is_boot, is_lock;
    logic [31:0]             rdata;
    logic                    boot_valid;
    logic [1:0]              boot_val;

    assign access   = psel_i & penable_i;
    assign word_ofs = {paddr_i[5:2], 2'b00};
    assign pad_base = word_ofs - PADCFG_BASE;
    assign is_pad   = word_ofs < PADCFG_END;
    assign is_boot  = word_ofs == BOOTSEL_OFS;
    assign is_lock  = word_ofs == LOCK_OFS;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            pad_q  <= pad_d;
            lock_q <= lock_d;
        end
    end

    always_comb begin
        pad_d  = pad_q;
        lock_d = lock_q;
        if (access && pwrite_i) begin
            if (is_pad && !lock_q) begin
                for (int j = 0; j < PADS_PER_WORD; j++)
                    pad_d[pad_base + 6'(j)] = pwdata_i[8*j +: PAD_CFG_W];
            end
            if (is_lock && pwdata_i[0])
                lock_d = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (is_pad) begin
            for (int j = 0; j < PADS_PER_WORD; j++)
                rdata[8*j +: PAD_CFG_W] = pad_q[pad_base + 6'(j)];
        end else if (is_boot) begin
            rdata[1:0] = boot_val;
            rdata[8]   = boot_valid;
        end else if (is_lock) begin
            rdata[0] = lock_q;
        end
    end

    assign prdata_o  = (access && !pwrite_i) ? rdata : '0;
    assign pslverr_o = access & (~(is_pad | is_boot | is_lock)
                                 | (pwrite_i & is_boot)
                                 | (pwrite_i & is_pad & lock_q));
    assign pready_o  = 1'b1;
    assign pad_cfg_o = pad_q;

    pad_bootsel_filter #(
        .BOOT_STABLE_CYCLES(BOOT_STABLE_CYCLES)
    ) u_filter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .bootsel_i(bootsel_i),
        .bootsel_o(boot_val),
        .valid_o  (boot_valid)
    );

    assign bootsel_o       = boot_val;
    assign bootsel_valid_o = boot_valid;

    logic unused_bits;
    assign unused_bits = ^{paddr_i[APB_ADDR_W-1:6], paddr_i[1:0],
                           pwdata_i[31:30], pwdata_i[23:22], pwdata_i[15:14], pwdata_i[7:6]};
endmodule

// File: tb/tb_apb_pad_ctrl.sv
// Randomized self-checking bench for apb_pad_ctrl against a register-map and
// run-length boot filter reference model.
module tb_apb_pad_ctrl;
    localparam int N    = 16;
    localparam int MAXE = 60;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
    logic [11:0] paddr_i = '0;
    logic [31:0] pwdata_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic [1:0]  bootsel_i = '0;
    logic [47:0][5:0] pad_cfg_o;
    logic [1:0]  bootsel_o;
    logic        bootsel_valid_o;

    int checks = 0, passed = 0;

    logic [5:0] m_pad[48];
    bit         m_lock;
    logic [1:0] m_boot;
    bit         m_bvalid;
    logic [1:0] fin[0:MAXE];

    always #5 clk = ~clk;

    apb_pad_ctrl #(.BOOT_STABLE_CYCLES(N), .APB_ADDR_W(12)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .psel_i(psel_i), .penable_i(penable_i),
        .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .bootsel_i(bootsel_i), .pad_cfg_o(pad_cfg_o), .bootsel_o(bootsel_o),
        .bootsel_valid_o(bootsel_valid_o)
    );

    // ---------------- reference model ----------------
    function automatic void m_clear();
        for (int p = 0; p < 48; p++) m_pad[p] = '0;
        m_lock = 0;
        m_boot = '0;
        m_bvalid = 0;
    endfunction

    function automatic bit m_write(logic [11:0] a, logic [31:0] d);
        int w = int'(a[5:2]);
        if (w < 12) begin
            if (m_lock) return 1;
            for (int j = 0; j < 4; j++) m_pad[w*4+j] = d[8*j +: 6];
            return 0;
        end
        if (w == 13) begin
            if (d[0]) m_lock = 1;
            return 0;
        end
        return 1;
    endfunction

    function automatic void m_read(logic [11:0] a, output logic [31:0] d, output bit e);
        int w = int'(a[5:2]);
        d = '0;
        e = 0;
        if (w < 12) for (int j = 0; j < 4; j++) d[8*j +: 6] = m_pad[w*4+j];
        else if (w == 12) d = {23'd0, m_bvalid, 6'd0, m_boot};
        else if (w == 13) d = {31'd0, m_lock};
        else e = 1;
    endfunction

    // ---------------- APB drivers ----------------
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output bit err);
        @(negedge clk);
        psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = a; pwdata_i = d;
        @(negedge clk);
        penable_i = 1;
        #1 err = pslverr_o;
        @(posedge clk);
        #1 psel_i = 0; penable_i = 0; pwrite_i = 0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output bit err);
        @(negedge clk);
        psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = a;
        @(negedge clk);
        penable_i = 1;
        #1 begin d = prdata_o; err = pslverr_o; end
        @(posedge clk);
        #1 psel_i = 0; penable_i = 0;
    endtask

    task automatic check_pads(input string name);
        logic [47:0][5:0] e;
        for (int p = 0; p < 48; p++) e[p] = m_pad[p];
        checks++;
        if (pad_cfg_o !== e) $display("FAIL %s: pad_cfg got %h exp %h", name, pad_cfg_o, e);
        else passed++;
    endtask

    task automatic check_rd(input string name, input logic [11:0] a);
        logic [31:0] d, ed;
        bit err, ee;
        apb_read(a, d, err);
        m_read(a, ed, ee);
        checks++;
        if ({err, d} !== {ee, ed}) $display("FAIL %s @%h: got err=%0b data=%h exp err=%0b data=%h", name, a, err, d, ee, ed);
        else passed++;
    endtask

    task automatic check_wr(input string name, input logic [11:0] a, input logic [31:0] d);
        bit err, ee;
        apb_write(a, d, err);
        ee = m_write(a, d);
        checks++;
        if (err !== ee) $display("FAIL %s @%h: pslverr got %0b exp %0b", name, a, err, ee);
        else passed++;
        check_pads(name);
    endtask

    // Runs the filter from reset with fin[e] applied before edge e; reports first valid edge.
    task automatic run_filter(input string name, output int rise);
        logic [1:0] smp[0:MAXE];
        int tv;
        bit eq;
        logic [1:0] eb;
        smp[0] = 2'b00;
        for (int t = 1; t <= MAXE; t++) smp[t] = (t >= 3) ? fin[t-2] : 2'b00;
        tv = MAXE + 1;
        for (int t = N; t <= MAXE && tv > MAXE; t++) begin
            eq = 1;
            for (int k = t - N; k <= t; k++) if (smp[k] != smp[t]) eq = 0;
            if (eq) tv = t;
        end
        rise = -1;
        @(negedge clk);
        rst_ni = 0; psel_i = 0; penable_i = 0;
        m_clear();
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1;
        for (int e = 1; e <= MAXE; e++) begin
            bootsel_i = fin[e];
            @(posedge clk);
            #1;
            eb = (e >= tv) ? smp[tv] : 2'b00;
            if (rise < 0 && bootsel_valid_o === 1'b1) rise = e;
            checks++;
            if ({bootsel_valid_o, bootsel_o} !== {(e >= tv), eb})
                $display("FAIL %s edge %0d: valid/boot got %b/%b exp %b/%b", name, e, bootsel_valid_o, bootsel_o, (e >= tv), eb);
            else passed++;
            @(negedge clk);
        end
        m_bvalid = (tv <= MAXE);
        m_boot   = m_bvalid ? smp[tv] : 2'b00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++;
        if ({pready_o, pslverr_o, prdata_o, bootsel_valid_o, bootsel_o} !== {1'b1, 1'b0, 32'd0, 1'b0, 2'b00})
            $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h v=%b b=%b exp 1 0 0 0 00",
                     pready_o, pslverr_o, prdata_o, bootsel_valid_o, bootsel_o);
        else passed++;
        m_clear();
        check_pads("reset_pads");
    endtask

    task automatic test_filter_held10();
        int rise;
        for (int e = 0; e <= MAXE; e++) fin[e] = (e > 25) ? 2'($urandom_range(0, 3)) : 2'b10;
        run_filter("filter_held10", rise);
        checks++;
        if (rise !== 19 || bootsel_o !== 2'b10) $display("FAIL filter10_latency: rise %0d boot %b exp 19 10", rise, bootsel_o);
        else passed++;
    endtask

    task automatic test_first_write();
        for (int w = 0; w < 12; w++) check_rd("padcfg_reset_read", 12'(w*4));
        check_wr("first_write", 12'h004, 32'h3F2A153F);
        checks++;
        if ({pad_cfg_o[4], pad_cfg_o[5], pad_cfg_o[6], pad_cfg_o[7]} !== {6'h3F, 6'h15, 6'h2A, 6'h3F})
            $display("FAIL first_write_pads: got %h %h %h %h exp 3f 15 2a 3f", pad_cfg_o[4], pad_cfg_o[5], pad_cfg_o[6], pad_cfg_o[7]);
        else passed++;
        check_rd("first_write_read", 12'h004);
    endtask

    task automatic test_unused_bits();
        logic [31:0] d;
        bit err;
        check_wr("unused_bits", 12'h02C, 32'hFFFFFFFF);
        apb_read(12'h02C, d, err);
        checks++;
        if (d !== 32'h3F3F3F3F) $display("FAIL unused_bits_read: got %h exp 3f3f3f3f", d);
        else passed++;
    endtask

    task automatic test_bootsel_read();
        logic [31:0] d;
        bit err;
        apb_read(12'h030, d, err);
        checks++;
        if ({err, d} !== {1'b0, 32'h102}) $display("FAIL bootsel_read: got err=%b %h exp 0 00000102", err, d);
        else passed++;
    endtask

    task automatic test_random_apb();
        logic [11:0] a;
        int w;
        for (int i = 0; i < 200; i++) begin
            w = $urandom_range(0, 15);
            a = {6'($urandom), 4'(w), 2'($urandom)};
            if ($urandom_range(0, 1) == 1 && w != 13) check_wr("rand_write", a, $urandom);
            else check_rd("rand_read", a);
        end
    endtask

    task automatic test_lock();
        logic [31:0] d;
        bit err;
        check_wr("lock_set", 12'h034, 32'h1);
        check_wr("locked_padcfg", 12'h000, 32'h0);
        apb_read(12'h034, d, err);
        checks++;
        if (d !== 32'h1) $display("FAIL lock_read: got %h exp 1", d);
        else passed++;
        check_wr("lock_write0", 12'h034, 32'h0);
        check_rd("lock_sticky", 12'h034);
        check_wr("locked_padcfg2", 12'h028, $urandom);
    endtask

    task automatic test_errors();
        logic [31:0] d;
        bit err;
        apb_read(12'h038, d, err);
        checks++;
        if ({err, d} !== {1'b1, 32'd0}) $display("FAIL unmapped_read: got err=%b %h exp 1 0", err, d);
        else passed++;
        check_wr("bootsel_write", 12'h030, 32'h0);
        checks++;
        if ({bootsel_valid_o, bootsel_o} !== 3'b110) $display("FAIL bootsel_write_noeffect: got %b exp 110", {bootsel_valid_o, bootsel_o});
        else passed++;
        check_rd("unmapped_3c", 12'h03C);
    endtask

    task automatic test_filter_zero();
        int rise;
        for (int e = 0; e <= MAXE; e++) fin[e] = 2'b00;
        run_filter("filter_zero", rise);
        checks++;
        if (rise !== 16) $display("FAIL filter_zero_latency: rise %0d exp 16", rise);
        else passed++;
    endtask

    task automatic test_filter_glitch();
        int rise;
        for (int e = 0; e <= MAXE; e++) fin[e] = (e == 10) ? 2'b01 : 2'b00;
        run_filter("filter_glitch", rise);
        checks++;
        if (rise !== 29) $display("FAIL filter_glitch_latency: rise %0d exp 29", rise);
        else passed++;
    endtask

    task automatic test_filter_random();
        int rise;
        logic [1:0] v;
        for (int r = 0; r < 4; r++) begin
            v = 2'($urandom_range(0, 3));
            for (int e = 0; e <= MAXE; e++) begin
                if ($urandom_range(0, 7) == 0) v = 2'($urandom_range(0, 3));
                fin[e] = v;
            end
            run_filter("filter_random", rise);
        end
    endtask

    task automatic test_reset_mid();
        int rise;
        bit err;
        for (int e = 0; e <= MAXE; e++) fin[e] = 2'b11;
        run_filter("filter_pre_mid", rise);
        check_wr("mid_write", 12'h000, 32'h01020304);
        // in-flight write interrupted by reset before its access edge
        @(negedge clk);
        psel_i = 1; penable_i = 1; pwrite_i = 1; paddr_i = 12'h004; pwdata_i = 32'h3F3F3F3F;
        #2 rst_ni = 0;
        #1;
        m_clear();
        checks++;
        if ({bootsel_valid_o, bootsel_o, prdata_o} !== {1'b0, 2'b00, 32'd0})
            $display("FAIL async_reset_outputs: got v=%b b=%b rd=%h exp 0 00 0", bootsel_valid_o, bootsel_o, prdata_o);
        else passed++;
        check_pads("async_reset_pads");
        @(posedge clk);
        #1;
        check_pads("inflight_lost");
        psel_i = 0; penable_i = 0; pwrite_i = 0;
        // release and abort mid-filter
        @(negedge clk);
        rst_ni = 1;
        bootsel_i = 2'b11;
        repeat (8) @(posedge clk);
        #2 rst_ni = 0;
        #1;
        checks++;
        if ({bootsel_valid_o, bootsel_o} !== 3'b000) $display("FAIL midfilter_reset: got %b exp 000", {bootsel_valid_o, bootsel_o});
        else passed++;
        run_filter("filter_relatch", rise);
        checks++;
        if (rise !== 19) $display("FAIL relatch_latency: rise %0d exp 19", rise);
        else passed++;
        apb_write(12'h008, 32'h05050505, err);
        err = m_write(12'h008, 32'h05050505);
        check_pads("post_reset_write");
    endtask

    initial begin
        test_reset();
        test_filter_held10();
        test_first_write();
        test_unused_bits();
        test_bootsel_read();
        test_random_apb();
        test_lock();
        test_errors();
        test_filter_zero();
        test_filter_glitch();
        test_filter_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/apb_pad_ctrl.md
# apb_pad_ctrl

APB3 register slave that generates the 48 × 6-bit pad configuration vector consumed by the pad frame (`pad_cfg_o` → `pad_cfg_i`). It also qualifies the two raw boot-select pad inputs and publishes a latched boot mode to the SoC. It sits in the SoC peripheral domain, between the APB interconnect and the pad frame.

## Interface
Parameters:
- `BOOT_STABLE_CYCLES`, default 16: consecutive stable synchronized cycles required before the boot-select value is latched. Must be ≥ 1.
- `APB_ADDR_W`, default 12: APB address width. Only `paddr_i[5:2]` is decoded.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset. Asynchronous assertion, active low.
- `psel_i` in 1: APB select.
- `penable_i` in 1: APB enable.
- `pwrite_i` in 1: APB write.
- `paddr_i` in APB_ADDR_W: APB address.
- `pwdata_i` in 32: APB write data.
- `prdata_o` out 32: APB read data.
- `pready_o` out 1: APB ready. Tied to 1.
- `pslverr_o` out 1: APB error.
- `bootsel_i` in 2: raw boot-select pad inputs (asynchronous).
- `pad_cfg_o` out [47:0][5:0]: pad configuration to the pad frame.
- `bootsel_o` out 2: latched boot mode.
- `bootsel_valid_o` out 1: `bootsel_o` is final.

## Operation
Register map (word offsets):
- **PADCFG0–11 (0x00–0x2C), RW.** Word k holds pads 4k..4k+3. Pad 4k+j maps to bits [8j+5:8j]. Bits [8j+7:8j+6] read 0 and writes to them are ignored.
- **BOOTSEL (0x30), RO.** [1:0] = `bootsel_o`, [8] = `bootsel_valid_o`, all other bits 0. Writes set `pslverr_o` and have no effect.
- **LOCK (0x34), RW1S.** Bit 0 = lock. Writing 1 sets it. Writing 0 has no effect. Only reset clears it.
- **Unmapped offsets (0x38–0x3C).** `prdata_o` = 0, `pslverr_o` = 1.

Write and error rules:
- PADCFG write while lock = 1: ignored, `pslverr_o` = 1.
- Reads never change state.

Boot-select filter FSM (states FILTER, DONE):
- `bootsel_i` passes through a 2-flop synchronizer (s1 → s2). Reset value 0.
- **FILTER:**
  - If s2 ≠ cand: cand ← s2, cnt ← 0.
  - Else if cnt == BOOT_STABLE_CYCLES−1: `bootsel_o` ← cand, `bootsel_valid_o` ← 1, go to DONE.
  - Else: cnt ← cnt+1.
- **DONE:** terminal state. Input changes are ignored until reset.
- Width rules: cnt is $clog2(BOOT_STABLE_CYCLES+1) bits and saturates, so it never wraps. cand is 2 bits, reset 0.

## Timing
- Reset values: `pad_cfg_o` all 0 (the pad frame's PEN = ~bit0 then enables pulls), `prdata_o` 0, `pslverr_o` 0, `pready_o` 1, `bootsel_o` 0, `bootsel_valid_o` 0. Lock = 0, FSM in FILTER, cnt = 0.
- APB is zero-wait-state:
  - Write: committed on the edge that ends the access phase (`psel_i & penable_i`). `pad_cfg_o` changes on that same edge.
  - Read: `prdata_o` is combinational from current state during the access phase.
  - `pslverr_o` is combinational and valid only during the access phase. It is 0 otherwise.
- Setup phase (`psel_i & ~penable_i`) has no effect.
- Write to LOCK takes effect on its access edge. A PADCFG access in the next transfer is therefore rejected.
- Boot-select latency, counting clock edges after reset release:
  - Constant `bootsel_i` = 0: valid rises on edge BOOT_STABLE_CYCLES.
  - Constant non-zero input: valid rises on edge BOOT_STABLE_CYCLES+3 (2 sync edges + 1 candidate-reload edge).
- Any glitch visible at s2 during FILTER restarts the count.
- Reset asserted mid-operation: all state returns to reset values immediately (async). The filter re-runs after release. The in-flight APB transfer is lost.

## Structure
- Package `pad_ctrl_pkg` holds:
  - `NUM_PADS` = 48, `PAD_CFG_W` = 6, `PADS_PER_WORD` = 4.
  - Register offset constants: `PADCFG_BASE`, `BOOTSEL_OFS`, `LOCK_OFS`.
  - `pad_cfg_t` typedef, logic [PAD_CFG_W-1:0].
  - FSM enum `bootsel_state_e`.
- Sub-module `pad_bootsel_filter`: synchronizer, counter and FSM. Parameter BOOT_STABLE_CYCLES. Ports `clk_i`, `rst_ni`, `bootsel_i`, `bootsel_o`, `valid_o`.
- Register file and APB decode stay in `apb_pad_ctrl`.

## Test plan
- **Reset and first write.** Reset, then read PADCFG0..11 → all 0. Write 0x3F2A153F to 0x04 → pad 4 = 0x3F, pad 5 = 0x15, pad 6 = 0x2A, pad 7 = 0x3F on the same edge. Read back → 0x3F2A153F.
- **Unused bits.** Write 0xFFFFFFFF to 0x2C → pads 44–47 = 0x3F. Read back → 0x3F3F3F3F.
- **Lock.** Write 1 to 0x34, then write 0 to 0x00 → `pslverr_o` = 1 and pad 0 unchanged. Read 0x34 → 1. Write 0 to 0x34 → lock stays 1.
- **Error responses.** Read 0x38 → `prdata_o` 0, `pslverr_o` 1. Write 0x30 → `pslverr_o` 1, `bootsel_o` unchanged.
- **Boot-select filter, N = 16.**
  - `bootsel_i` = 2'b10 held from reset → valid rises on edge 19, `bootsel_o` = 2'b10. Read 0x30 → 0x102.
  - `bootsel_i` = 0 held → valid on edge 16.
  - One-cycle 2'b01 glitch at edge 10 → count restarts and valid is delayed accordingly.
  - Toggle `bootsel_i` after valid → `bootsel_o` unchanged.
- **Reset mid-operation.** Assert `rst_ni` mid-filter and after a PADCFG write → all outputs return to reset values asynchronously. The filter re-latches after release.
